// File: rtl/cute_sel_pkg.sv
// Shared definitions for the demux_seq block: bank width, the ten legal
// destination codes, the scan FSM state type and the index-to-code helper.
package cute_sel_pkg;

   localparam int NUM_OUT = 10;

   // Legal destination codes, listed in index (and scan) order.
   localparam logic [3:0] CODE_0 = 4'b0000;
   localparam logic [3:0] CODE_1 = 4'b0001;
   localparam logic [3:0] CODE_2 = 4'b0010;
   localparam logic [3:0] CODE_3 = 4'b0011;
   localparam logic [3:0] CODE_4 = 4'b0100;
   localparam logic [3:0] CODE_5 = 4'b0101;
   localparam logic [3:0] CODE_6 = 4'b0110;
   localparam logic [3:0] CODE_7 = 4'b0111;
   localparam logic [3:0] CODE_8 = 4'b1101;
   localparam logic [3:0] CODE_9 = 4'b1110;

   localparam logic [3:0] LAST_IDX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Index -> legal code; out-of-range indices map to the idle code.
   function automatic logic [3:0] code_of(input logic [3:0] idx);
      logic [3:0] c;
      case (idx)
         4'd0:    c = CODE_0;
         4'd1:    c = CODE_1;
         4'd2:    c = CODE_2;
         4'd3:    c = CODE_3;
         4'd4:    c = CODE_4;
         4'd5:    c = CODE_5;
         4'd6:    c = CODE_6;
         4'd7:    c = CODE_7;
         4'd8:    c = CODE_8;
         4'd9:    c = CODE_9;
         default: c = CODE_0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/demux_seq_if.sv
// Bus bundle for demux_seq.
// Inputs: din, sel[3:0], wr_en, start, clr. Outputs: otp[9:0], sel_out[3:0],
// busy, done, err, parity. master = driver side, slave = the demux block.
interface demux_seq_if;
   import cute_sel_pkg::*;

   logic               din;
   logic [3:0]         sel;
   logic               wr_en;
   logic               start;
   logic               clr;
   logic [NUM_OUT-1:0] otp;
   logic [3:0]         sel_out;
   logic               busy;
   logic               done;
   logic               err;
   logic               parity;

   modport master (
      output din, sel, wr_en, start, clr,
      input  otp, sel_out, busy, done, err, parity
   );

   modport slave (
      input  din, sel, wr_en, start, clr,
      output otp, sel_out, busy, done, err, parity
   );

endinterface

// File: rtl/sel_decode.sv
// Maps a 4-bit destination code to {legal, index}.
// Ports: code[3:0] in; legal out (1 = code is one of the ten legal codes);
// index[3:0] out (0..9 for legal codes, 0 otherwise).
module sel_decode
   import cute_sel_pkg::*;
(
   input  logic [3:0] code,
   output logic       legal,
   output logic [3:0] index
);

   always_comb begin
      legal = 1'b1;
      index = 4'd0;
      case (code)
         CODE_0:  index = 4'd0;
         CODE_1:  index = 4'd1;
         CODE_2:  index = 4'd2;
         CODE_3:  index = 4'd3;
         CODE_4:  index = 4'd4;
         CODE_5:  index = 4'd5;
         CODE_6:  index = 4'd6;
         CODE_7:  index = 4'd7;
         CODE_8:  index = 4'd8;
         CODE_9:  index = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/demux_seq.sv
// 1:10 sequential demux: manual coded writes into a registered bank, or an
// automatic 10-step scan that captures din once per destination.
// Ports: clk, rst_n (async, active-low), bus (demux_seq_if.slave).
// Option: define DEMUX_SEQ_PARITY_EN for a registered parity of the bank.
module demux_seq
   import cute_sel_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   demux_seq_if.slave  bus
);

   state_e             state;
   state_e             state_nx;
   logic [3:0]         idx;
   logic [3:0]         idx_nx;
   logic [NUM_OUT-1:0] otp_q;
   logic [NUM_OUT-1:0] otp_nx;
   logic               err_q;
   logic               err_nx;
   logic               wr_legal;
   logic [3:0]         wr_idx;

   sel_decode u_dec (
      .code  (bus.sel),
      .legal (wr_legal),
      .index (wr_idx)
   );

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      otp_nx   = otp_q;
      err_nx   = err_q;
      case (state)
         ST_IDLE: begin
            // start wins; a same-cycle write is dropped
            if (bus.start) begin
               state_nx = ST_SCAN;
               idx_nx   = 4'd0;
            end else if (bus.wr_en) begin
               if (wr_legal) otp_nx[wr_idx] = bus.din;
               else          err_nx         = 1'b1;
            end
         end
         ST_SCAN: begin
            otp_nx[idx] = bus.din;
            if (idx == LAST_IDX) begin
               state_nx = ST_DONE;
               idx_nx   = 4'd0;
            end else begin
               idx_nx = idx + 4'd1;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
            idx_nx   = 4'd0;
         end
      endcase
      // clear overrides any write/capture but leaves the FSM running
      if (bus.clr) begin
         otp_nx = '0;
         err_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= 4'd0;
         otp_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         otp_q <= otp_nx;
         err_q <= err_nx;
      end
   end

   assign bus.otp     = otp_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state == ST_SCAN);
   assign bus.done    = (state == ST_DONE);
   assign bus.sel_out = (state == ST_SCAN) ? code_of(idx) : 4'b0000;

`ifdef DEMUX_SEQ_PARITY_EN
   // Registered from the next bank value so it lines up with otp.
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= ^otp_nx;
   end

   assign bus.parity = par_q;
`else
   assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_demux_seq.sv
// Scoreboard bench for demux_seq: driver pushes model predictions,
// monitor pops and compares after every rising edge.
module tb_demux_seq;
  import cute_sel_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  demux_seq_if bus();

  demux_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9:0] otp;
    logic       err;
    logic       busy;
    logic       done;
    logic [3:0] sel_out;
    logic       parity;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [9:0] m_otp;
  logic       m_err;
  int         m_pos;

  function automatic logic [3:0] ref_code(int i);
    if (i < 8) return 4'(i);
    if (i == 8) return 4'b1101;
    return 4'b1110;
  endfunction

  function automatic int ref_index(logic [3:0] c);
    if (c < 4'd8) return int'(c);
    if (c == 4'b1101) return 8;
    if (c == 4'b1110) return 9;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.otp     = m_otp;
    e.err     = m_err;
    e.busy    = (m_pos >= 0) && (m_pos < 10);
    e.done    = (m_pos == 10);
    e.sel_out = e.busy ? ref_code(m_pos) : 4'b0000;
`ifdef DEMUX_SEQ_PARITY_EN
    e.parity  = ^m_otp;
`else
    e.parity  = 1'b0;
`endif
    return e;
  endfunction

  task automatic step(logic d, logic [3:0] s, logic w,
                      logic st, logic c);
    int ix;
    @(negedge clk);
    bus.din   = d;
    bus.sel   = s;
    bus.wr_en = w;
    bus.start = st;
    bus.clr   = c;
    if (m_pos < 0) begin
      if (st) m_pos = 0;
      else if (w) begin
        ix = ref_index(s);
        if (ix >= 0) m_otp[ix] = d;
        else m_err = 1'b1;
      end
    end else if (m_pos < 10) begin
      m_otp[m_pos] = d;
      m_pos++;
    end else begin
      m_pos = -1;
    end
    if (c) begin
      m_otp = '0;
      m_err = 1'b0;
    end
    q.push_back(model_out());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_otp"}, 32'(bus.otp), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sel_out"}, 32'(bus.sel_out), 32'd0);
    chk({tag, "_parity"}, 32'(bus.parity), 32'd0);
  endtask

  task automatic do_reset(int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_done", 32'(bus.done), 32'd0);
      chk("rst_hold_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_otp = '0;
    m_err = 1'b0;
    m_pos = -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("otp", 32'(bus.otp), 32'(e.otp));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("sel_out", 32'(bus.sel_out), 32'(e.sel_out));
        chk("parity", 32'(bus.parity), 32'(e.parity));
      end
    end
  end

  initial begin : driver
    logic [9:0] pat;
    bus.din = 1'b0;
    bus.sel = 4'd0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    bus.clr = 1'b0;
    m_otp = '0;
    m_err = 1'b0;
    m_pos = -1;

    #1 rst_n = 1'b0;
    #2;
    chk_reset_vals("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // manual write to code 1101 -> bit 8
    step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("wr_1101_otp", 32'(bus.otp), 32'h100);
    chk("wr_1101_err", 32'(bus.err), 32'd0);
    step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);

    // illegal code: no write, sticky err until clr
    step(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(2);
    @(posedge clk);
    #2;
    chk("illegal_err_sticky", 32'(bus.err), 32'd1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // scan with fixed pattern, index order 0..9
    pat = 10'b11_0100_1101;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      step(pat[i], 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scan_otp", 32'(bus.otp), 32'h34D);
    chk("scan_done_c11", 32'(bus.done), 32'd1);
    chk("scan_parity", 32'(bus.parity), 32'd0);
    idle(2);

    // start + wr_en: scan wins, write lost; wr_en/start during scan ignored
    step(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 5; i < 10; i++)
      step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b1011, 1'b1, 1'b1, 1'b0);
    idle(1);

    // reset in the middle of a scan aborts it
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    do_reset(3);
    idle(12);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0));
    idle(12);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_seq.md
DEMUX_SEQ -- requirements
Module: demux_seq

Interface
REQ-001 SHALL have no parameters; output bank width is fixed at 10 (NUM_OUT, from package).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  1  data bit to route.
REQ-005 sel  input  4  manual destination code {c1,c2,c3,c4}.
REQ-006 wr_en  input  1  manual write strobe, one write per cycle.
REQ-007 start  input  1  single-cycle pulse that begins an automatic scan.
REQ-008 clr  input  1  synchronous clear of the output bank.
REQ-009 otp  output  10  registered output bank; bit k is destination k.
REQ-010 sel_out  output  4  current scan code, intended to drive an upstream 10:1 selector.
REQ-011 busy  output  1  high while in SCAN.
REQ-012 done  output  1  one-cycle pulse after the scan completes.
REQ-013 err  output  1  sticky illegal-code flag.
REQ-014 parity  output  1  XOR of otp (see Configuration).

Function
REQ-015 Legal code map SHALL be 0000..0111 -> index 0..7, 1101 -> 8, 1110 -> 9; codes 1000-1100 and 1111 are illegal.
REQ-016 FSM states SHALL be IDLE, SCAN, DONE.
REQ-017 IDLE: wr_en=1 with legal sel SHALL write din into otp[index] at the next edge; other bits hold.
REQ-018 IDLE: wr_en=1 with illegal sel SHALL perform no write and set err at the next edge.
REQ-019 IDLE: start=1 SHALL move to SCAN with scan index 0; start takes priority over a simultaneous wr_en, and that wr_en is dropped.
REQ-020 SCAN: each cycle SHALL capture din into otp[scan index] and advance the index by one.
REQ-021 sel_out SHALL present the legal code of the current scan index combinationally from the index register; this gives a 1-cycle turn-around through an external combinational selector.
REQ-022 SCAN ordering SHALL be the code sequence 0000,0001,...,0111,1101,1110; the capture at index 9 SHALL be followed by DONE.
REQ-023 A scan SHALL take exactly 10 cycles in SCAN, followed by 1 cycle in DONE, then IDLE.
REQ-024 In SCAN and DONE, wr_en and start SHALL be ignored and SHALL NOT set err.
REQ-025 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 busy SHALL be high in SCAN only.
REQ-027 sel_out SHALL be 0000 when not in SCAN.
REQ-028 clr=1 SHALL zero otp and err at the next edge in any state and SHALL take priority over any same-cycle write or capture; the FSM state is unaffected.
REQ-029 err SHALL clear only on reset or clr.

Reset
REQ-030 On rst_n=0, all of the following SHALL be forced immediately, independent of clk: otp=0, err=0, sel_out=0000, busy=0, done=0, parity=0, state=IDLE, scan index=0.
REQ-031 Reset asserted during SCAN SHALL abort the scan with no done pulse.
REQ-032 Release of rst_n SHALL be synchronised externally; the block SHALL act from the first rising edge after release.

Configuration
REQ-033 Macro DEMUX_SEQ_PARITY_EN: when defined, parity SHALL be a registered XOR-reduce of the next otp value, so that it tracks otp with zero visible lag.
REQ-034 When DEMUX_SEQ_PARITY_EN is not defined, parity SHALL be tied to 0 and no parity register SHALL exist.

Structure
REQ-035 Package cute_sel_pkg SHALL hold NUM_OUT=10, the 10 legal code constants, and the FSM state enum typedef.
REQ-036 A sub-module sel_decode SHALL map a 4-bit code to {legal, 4-bit index}; the code-from-index mapping for sel_out SHALL use package constants.

Verification
REQ-037 Reset: hold rst_n=0 mid-SCAN -> otp=0, busy=0, done never pulses, sel_out=0000.
REQ-038 Manual write: sel=1101, din=1, wr_en=1 -> otp=10'b01_0000_0000 next cycle, err=0.
REQ-039 Illegal code: sel=1010, wr_en=1, din=1 -> otp unchanged, err=1 and it stays 1 until clr.
REQ-040 Scan: start pulse, din driven to pattern 1,0,1,1,0,0,1,0,1,1 in index order -> after 10 cycles otp=10'b11_0100_1101, sel_out walked 0000..0111,1101,1110, done pulses in the cycle 11 after start.
REQ-041 Collisions: start+wr_en in the same cycle -> scan begins and the write is lost; wr_en during SCAN -> ignored; clr during SCAN at index 4 -> otp=0 at that edge and the scan continues to done.
REQ-042 Parity: with DEMUX_SEQ_PARITY_EN, after the REQ-040 scan -> parity=0 (six ones); without the macro -> parity always 0.
